// File: rtl/text_pkg.sv
// Shared definitions for the on-screen text path: character codes,
// buffer geometry and the writer state encoding.
package text_pkg;

    localparam int         COLS       = 16;
    localparam logic [7:0] ASCII_ZERO = 8'd48;
    localparam logic [7:0] BLANK_CODE = 8'h20;

    typedef logic [7:0] char_addr_t;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_CONVERT,
        ST_WRITE
    } state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary to 5-digit packed BCD,
// one iteration per clock. valid is high for the cycle after the last
// iteration; bcd then holds the result until the next start.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        valid,
    output logic [19:0] bcd
);

    logic [35:0] shift_reg;
    logic [4:0]  iter_left;

    // add 3 to every BCD nibble that is 5 or more, then shift {bcd, bin} left
    function automatic logic [35:0] dd_step(input logic [35:0] v);
        logic [35:0] a;
        a = v;
        for (int n = 0; n < 5; n++) begin
            if (a[16+4*n +: 4] >= 4'd5) begin
                a[16+4*n +: 4] = a[16+4*n +: 4] + 4'd3;
            end
        end
        return {a[34:0], 1'b0};
    endfunction

    // load on start, then run 16 iterations and flag completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            iter_left <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
        end else if (start) begin
            shift_reg <= {20'd0, bin};
            iter_left <= 5'd16;
            busy      <= 1'b1;
            valid     <= 1'b0;
        end else if (busy) begin
            shift_reg <= dd_step(shift_reg);
            iter_left <= iter_left - 5'd1;
            if (iter_left == 5'd1) begin
                busy  <= 1'b0;
                valid <= 1'b1;
            end
        end else begin
            valid <= 1'b0;
        end
    end

    assign bcd = shift_reg[35:16];

endmodule

// File: rtl/score_text_writer.sv
// Score-to-text producer. Clears the 256-entry character buffer, then
// converts each new score to decimal and writes the digits into one row
// of the buffer. The overlay drawer reads the buffer through a
// registered, read-first port.
//
//   state      | meaning
//   -----------+----------------------------------------------------
//   ST_CLEAR   | blank all 256 cells, one per cycle, then latch score
//   ST_IDLE    | wait for score_in to differ from the latched score
//   ST_CONVERT | double-dabble running; writes digit 0 when it lands
//   ST_WRITE   | write digits 1..DIGITS-1, pulse done after the last
module score_text_writer #(
    parameter int         COLS       = text_pkg::COLS,
    parameter int         DIGITS     = 5,
    parameter int         TEXT_ROW   = 0,
    parameter int         TEXT_COL   = 0,
    parameter logic [7:0] ASCII_ZERO = text_pkg::ASCII_ZERO,
    parameter logic [7:0] BLANK_CODE = text_pkg::BLANK_CODE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] score_in,
    input  logic [7:0]  char_xy,
    output logic [7:0]  char_code,
    output logic        busy,
    output logic        done
);

    import text_pkg::*;

    localparam int         LAST_ADDR = TEXT_COL + DIGITS - 1 + COLS * TEXT_ROW;
    localparam char_addr_t BASE      = char_addr_t'(TEXT_COL + COLS * TEXT_ROW);
    localparam logic [2:0] LAST_IDX  = 3'(DIGITS - 1);

    // the digit field must fit in the buffer and in the 5-digit converter
    generate
        if (LAST_ADDR > 255 || DIGITS < 1 || DIGITS > 5 ||
            TEXT_ROW < 0 || TEXT_COL < 0 || COLS < 1) begin : g_cfg_err
            $error("score_text_writer: digit field does not fit the 256-entry buffer");
        end
    endgenerate

    state_t      state;
    char_addr_t  clr_addr;
    logic [2:0]  idx;
    logic [15:0] last_score;
    logic        seen_nz;

    logic        cv_start;
    logic        cv_busy;
    logic        cv_valid;
    logic        conv_ready;
    logic [19:0] cv_bcd;

    logic [2:0]  wr_idx;
    logic [19:0] bcd_sh;
    logic [3:0]  digit;
    logic        prev_nz;
    logic        wr_last;
    logic        blank_digit;
    logic        wr_en;
    char_addr_t  wr_addr;
    logic [7:0]  wr_data;

    logic [7:0]  mem [256];

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (cv_start),
        .bin   (score_in),
        .busy  (cv_busy),
        .valid (cv_valid),
        .bcd   (cv_bcd)
    );

    // conversion starts when CLEAR ends or when IDLE sees a new score
    always_comb begin
        cv_start   = ((state == ST_CLEAR) && (clr_addr == 8'hFF)) ||
                     ((state == ST_IDLE) && (score_in != last_score));
        conv_ready = cv_valid && !cv_busy;
    end

    // write-port decode: blanking sweep in CLEAR, digit writes otherwise
    always_comb begin
        wr_idx      = (state == ST_WRITE) ? idx : 3'd0;
        bcd_sh      = cv_bcd >> {LAST_IDX - wr_idx, 2'b00};
        digit       = bcd_sh[3:0];
        prev_nz     = (state == ST_WRITE) && seen_nz;
        wr_last     = (wr_idx == LAST_IDX);
        blank_digit = !prev_nz && (digit == 4'd0) && !wr_last;
        wr_en       = 1'b0;
        wr_addr     = clr_addr;
        wr_data     = BLANK_CODE;
        case (state)
            ST_CLEAR:   wr_en = 1'b1;
            ST_CONVERT: wr_en = conv_ready;
            ST_WRITE:   wr_en = 1'b1;
            default:    wr_en = 1'b0;
        endcase
        if (state != ST_CLEAR) begin
            wr_addr = BASE + char_addr_t'(wr_idx);
            wr_data = blank_digit ? BLANK_CODE : (ASCII_ZERO + {4'd0, digit});
        end
    end

    // sequencing FSM with registered busy/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_CLEAR;
            clr_addr   <= '0;
            idx        <= '0;
            last_score <= '0;
            seen_nz    <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    clr_addr <= clr_addr + 8'd1;
                    if (clr_addr == 8'hFF) begin
                        last_score <= score_in;
                        state      <= ST_CONVERT;
                    end
                end
                ST_IDLE: begin
                    if (cv_start) begin
                        last_score <= score_in;
                        busy       <= 1'b1;
                        state      <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    if (conv_ready) begin
                        seen_nz <= (digit != 4'd0);
                        if (wr_last) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            idx   <= 3'd1;
                            state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    seen_nz <= seen_nz | (digit != 4'd0);
                    if (wr_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    // character buffer write port (no reset: inferred RAM)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // registered read port; old data wins on a same-address write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_code <= BLANK_CODE;
        end else begin
            char_code <= mem[char_xy];
        end
    end

endmodule

// File: tb/tb_score_text_writer.sv
// Bench for score_text_writer: an edge-level timeline model of the
// buffer, busy and done, checked every cycle, plus directed scenarios
// with hand-computed expectations.
module tb_score_text_writer;

    localparam int DIGITS = 5;
    localparam logic [7:0] BL = 8'h20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] score_in = 16'd0;
    logic [7:0]  char_xy = 8'd0;
    logic [7:0]  char_code;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    score_text_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .score_in  (score_in),
        .char_xy   (char_xy),
        .char_code (char_code),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // displayed character i (0 = most significant) for a score value
    function automatic logic [7:0] model_char(input int v, input int i);
        int p;
        p = 1;
        for (int j = 0; j < DIGITS - 1 - i; j++) p = p * 10;
        if (i != DIGITS - 1 && (v / p) == 0) return BL;
        return 8'(48 + (v / p) % 10);
    endfunction

    // ---------------- timeline model ----------------
    logic [7:0] exp_mem [256];
    bit         known [256];
    int         t_edge = 0;     // edges since reset release
    int         k_latch = -1;   // edge at which current conversion latched
    int         lat_val = 0;
    bit         m_busy = 1'b1;
    bit         m_done = 1'b0;
    logic [7:0] m_code = BL;
    bit         m_known = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_edge  = 0;
            k_latch = -1;
            m_busy  = 1'b1;
            m_done  = 1'b0;
            m_code  = BL;
            m_known = 1'b1;
            for (int a = 0; a < 256; a++) known[a] = 1'b0;
        end else begin
            m_code  = exp_mem[char_xy];
            m_known = known[char_xy];
            m_done  = 1'b0;
            t_edge++;
            if (t_edge <= 256) begin
                exp_mem[t_edge-1] = BL;
                known[t_edge-1]   = 1'b1;
                if (t_edge == 256) begin
                    k_latch = t_edge;
                    lat_val = int'(score_in);
                end
            end else if (k_latch >= 0) begin
                int d;
                d = t_edge - k_latch;
                if (d >= 17 && d <= 21) begin
                    exp_mem[d-17] = model_char(lat_val, d - 17);
                    known[d-17]   = 1'b1;
                end
                if (d == 21) begin
                    m_done  = 1'b1;
                    m_busy  = 1'b0;
                    k_latch = -1;
                end
            end else if (int'(score_in) != lat_val) begin
                k_latch = t_edge;
                lat_val = int'(score_in);
                m_busy  = 1'b1;
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("done", {31'd0, done}, {31'd0, m_done});
        if (m_known) chk("char_code", {24'd0, char_code}, {24'd0, m_code});
    end

    // ---------------- directed helpers ----------------
    task automatic do_reset();
        @(negedge clk); #1 rst_n = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic read_chk(input string name, input logic [7:0] addr, input logic [7:0] exp);
        @(negedge clk);
        char_xy = addr;
        @(posedge clk); #1;
        chk(name, {24'd0, char_code}, {24'd0, exp});
    endtask

    // edges until done is seen, 0 if bound expires
    task automatic edges_to_done(input int bound, output int n);
        n = 0;
        for (int i = 1; i <= bound; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (!busy) break;
        end
        if (i == bound) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_row(input string name, input logic [7:0] e0, e1, e2, e3, e4);
        logic [7:0] e [5];
        e = '{e0, e1, e2, e3, e4};
        for (int i = 0; i < 5; i++) read_chk(name, 8'(i), e[i]);
    endtask

    task automatic set_score(input logic [15:0] v);
        @(negedge clk);
        score_in = v;
    endtask

    initial begin
        int n;
        int dcnt;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_code", {24'd0, char_code}, 32'h20);
        @(negedge clk); #1 rst_n = 1'b1;

        // score 0 after CLEAR
        edges_to_done(400, n);
        chk("clear_to_done", n, 277);
        for (int a = 0; a < 256; a++)
            read_chk("zero_buf", 8'(a), (a == 4) ? 8'h30 : 8'h20);

        // 12345 with latency
        set_score(16'd12345);
        edges_to_done(40, n);
        chk("lat_12345", n, 22);
        check_row("row_12345", 8'h31, 8'h32, 8'h33, 8'h34, 8'h35);

        set_score(16'd1007);
        wait_idle(40);
        check_row("row_1007", 8'h20, 8'h31, 8'h30, 8'h30, 8'h37);

        set_score(16'd65535);
        wait_idle(40);
        check_row("row_65535", 8'h36, 8'h35, 8'h35, 8'h33, 8'h35);

        // changes during CONVERT
        set_score(16'd5);
        repeat (3) @(negedge clk);
        score_in = 16'd9;
        repeat (3) @(negedge clk);
        score_in = 16'd42;
        dcnt = 0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("done_pulses_1to2", {31'd0, (dcnt >= 1 && dcnt <= 2)}, 32'd1);
        check_row("row_42", 8'h20, 8'h20, 8'h20, 8'h34, 8'h32);

        // read-first on address 4
        @(negedge clk);
        char_xy  = 8'd4;
        score_in = 16'd7;
        edges_to_done(40, n);
        chk("rf_lat", n, 22);
        chk("rf_old", {24'd0, char_code}, 32'h32);
        @(posedge clk); #1;
        chk("rf_new", {24'd0, char_code}, 32'h37);

        // reset during WRITE
        set_score(16'd500);
        repeat (19) @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd1);
        chk("midrst_done", {31'd0, done}, 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        edges_to_done(400, n);
        chk("midrst_rerun", n, 277);
        check_row("row_500", 8'h20, 8'h20, 8'h35, 8'h30, 8'h30);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            char_xy = 8'($urandom);
            if ($urandom_range(0, 40) == 0) begin
                case ($urandom_range(0, 4))
                    0: score_in = 16'($urandom_range(0, 65535));
                    1: score_in = 16'($urandom_range(0, 120));
                    2: score_in = 16'd65535;
                    3: score_in = 16'd10000;
                    default: score_in = 16'd9999;
                endcase
            end
            if ($urandom_range(0, 1500) == 0) begin
                #1 rst_n = 1'b0;
                @(negedge clk); #1 rst_n = 1'b1;
            end
        end
        wait_idle(400);
        repeat (2) @(negedge clk);
        wait_idle(100);
        for (int i = 0; i < 5; i++)
            read_chk("final_row", 8'(i), model_char(int'(score_in), i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/score_text_writer.md
# score_text_writer

Producer side of the on-screen text path. Converts the 16-bit game score into decimal ASCII digits and writes them into a 256-entry character buffer. The text overlay drawer reads that buffer through a registered `char_xy -> char_code` port, with the same address layout and one-cycle latency the drawer already expects. Sits between the game logic (score source) and the text overlay drawer, in the pixel clock domain.

## Interface
Parameters:
- `COLS`, 16: characters per text row. Address = col + COLS*row.
- `DIGITS`, 5: number of decimal digits written.
- `TEXT_ROW`, 0: buffer row holding the score.
- `TEXT_COL`, 0: buffer column of the most significant digit.
- `ASCII_ZERO`, 48: code written for digit 0.
- `BLANK_CODE`, 8'h20: code for empty cells and suppressed leading zeros.

Ports:
- `clk`, in, 1: pixel clock. The single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `score_in`, in, 16: current score, unsigned.
- `char_xy`, in, 8: read address from the drawer.
- `char_code`, out, 8: registered read data.
- `busy`, out, 1: high in CLEAR, CONVERT and WRITE.
- `done`, out, 1: one-cycle pulse after the last digit write.

## Operation
- Reset values: `char_code`=BLANK_CODE, `busy`=1, `done`=0, state=CLEAR, clear address=0.
- CLEAR:
  - Writes BLANK_CODE to addresses 0..255, one per cycle, for 256 cycles.
  - Then latches `score_in` and enters CONVERT unconditionally.
- IDLE: `busy`=0. When `score_in` differs from the last latched score, latch `score_in` and enter CONVERT.
- CONVERT:
  - Sequential double-dabble, 16 iterations, one per cycle.
  - Each iteration adds 3 to every BCD nibble that is ≥5, then shifts the combined {BCD, binary} register left by 1.
  - BCD register is 20 bits. 65535 fits without overflow.
- WRITE:
  - One digit per cycle, most significant first, DIGITS cycles.
  - Digit i goes to address TEXT_COL + i + COLS*TEXT_ROW.
  - Leading zeros are written as BLANK_CODE. The least significant digit is always written as a numeral.
  - After the last write: `done`=1 for one cycle, then go to IDLE.
- Score change while busy: the latched value is completed. The IDLE compare then sees the newer value and restarts. Intermediate values may be skipped; the final value is always displayed.
- Read port:
  - Always active, including during CLEAR.
  - `char_code` <= mem[`char_xy`] every edge.
  - A read and a write to the same address in the same cycle return the old data (read-first).
- Reset mid-operation: aborts immediately and restarts CLEAR. Buffer contents are not guaranteed until CLEAR finishes.
- Addresses are 8-bit and wrap modulo 256. Parameter combinations that overflow 255 are a configuration error; a synthesis-time check is required.

## Timing
- Read latency: 1 cycle, `char_xy` at edge k gives `char_code` valid after edge k.
- From reset release: CLEAR takes 256 edges, then conversion starts.
- Conversion, for a new score sampled at edge k:
  - Edges k+1..k+16: CONVERT iterations.
  - Edges k+17..k+21: digit writes.
  - `done` high during the cycle after edge k+21. `busy` falls at edge k+21.
- Back-to-back: if `score_in` changed during conversion, IDLE lasts exactly one cycle before the next latch.
- `done` and the final write share edge k+21. A read issued at edge k+22 sees the new digit.

## Structure
- Shared package `text_pkg`:
  - ASCII_ZERO, BLANK_CODE, COLS.
  - State encoding: CLEAR, IDLE, CONVERT, WRITE.
  - `char_addr` type (8 bit).
- Sub-module `bin2bcd_seq`:
  - Ports: start/busy/valid handshake, 16-bit binary in, 20-bit BCD out.
  - Instantiated once.
- The buffer is an inferred 256x8 simple dual-port RAM in this module: synchronous write port plus registered read port, read-first.

## Test plan
- Reset, release, hold `score_in`=0 → after 256+22 cycles, reading address 0..3 gives 8'h20, address 4 gives 8'h30, address 5..255 gives 8'h20.
- `score_in`=12345 after idle → `done` 22 edges after the change; addresses 0..4 read 8'h31,32,33,34,35.
- `score_in`=1007 → addresses 0..4 read 8'h20,31,30,30,37 (internal zeros kept, leading zero blanked).
- `score_in`=65535 → 8'h36,35,35,33,35. No overflow.
- `score_in` 5→9→42 changing during CONVERT → only final value 42 guaranteed: addresses 0..4 read 20,20,20,34,32. `done` pulses at most twice.
- Read address 4 in the same cycle it is written → old code returned; next read returns the new code. Assert `rst_n` low mid-WRITE → `busy`=1, `done`=0, full CLEAR rerun.
